// File: rtl/bram_cnt_pkg.sv
// Shared encodings and defaults for the coincidence-count BRAM sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package bram_cnt_pkg;

  localparam int ADDR_W_DEF = 7;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ACC_RD   = 3'd1,
    ST_ACC_WB   = 3'd2,
    ST_HOST_RD  = 3'd3,
    ST_HOST_RSP = 3'd4,
    ST_HOST_WR  = 3'd5,
    ST_CLEAR    = 3'd6
  } state_t;

  localparam logic [1:0] GRANT_ACC  = 2'b01;
  localparam logic [1:0] GRANT_HOST = 2'b10;

endpackage

// File: rtl/bram_rr_arb2.sv
// Two-requester round-robin arbiter (req[0]=acc, req[1]=host), one-hot grant.
// Latency: grant is combinational from req; history updates on advance.
// Backpressure: grant is only honoured when adv is high; otherwise history is held.
module bram_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       adv,
  output logic [1:0] grant
);
  import bram_cnt_pkg::*;

  logic [1:0] last_grant;

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = GRANT_ACC;
      2'b10:   grant = GRANT_HOST;
      2'b11:   grant = (last_grant == GRANT_ACC) ? GRANT_HOST : GRANT_ACC;
      default: grant = 2'b00;
    endcase
  end

  // Host counts as the previous winner out of reset so acc takes the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= GRANT_HOST;
    end else if (adv && (req != 2'b00)) begin
      last_grant <= grant;
    end
  end

endmodule

// File: rtl/bram_count_arbiter.sv
// Serialises accumulate RMW, host read/write and clear sweep onto one BRAM port; BRAM_CNT_SAT_EN enables saturating increments.
// Latency: acc accept->write-back 2 cycles, host read accept->rvalid 3, host write 1, clear DEPTH cycles.
// Backpressure: acc_ready/host_ready only in IDLE with no clear pending; requesters hold valid until ready.
module bram_count_arbiter #(
  parameter int ADDR_W = bram_cnt_pkg::ADDR_W_DEF,
  parameter int DATA_W = bram_cnt_pkg::DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              acc_valid,
  input  logic [ADDR_W-1:0] acc_addr,
  output logic              acc_ready,
  input  logic              host_valid,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ready,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic              sat_flag,
  output logic              bram_en,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_din,
  input  logic [DATA_W-1:0] bram_dout
);
  import bram_cnt_pkg::*;

  localparam int DEPTH = 2 ** ADDR_W;

  state_t            state, state_nxt;
  logic              clr_pend;
  logic              clr_accept;
  logic              clr_last;
  logic              arb_adv;
  logic [1:0]        grant;
  logic [DATA_W-1:0] din_q;
  logic [DATA_W-1:0] acc_inc;

  assign clr_busy   = clr_pend | (state == ST_CLEAR);
  assign clr_accept = clr_start & ~clr_busy;
  assign clr_last   = (bram_addr == ADDR_W'(DEPTH - 1));
  assign arb_adv    = (state == ST_IDLE) & ~clr_pend;

  bram_rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .req   ({host_valid, acc_valid}),
    .adv   (arb_adv),
    .grant (grant)
  );

`ifdef BRAM_CNT_SAT_EN
  logic sat_q;
  logic sat_hit;

  assign sat_hit  = &bram_dout;
  assign acc_inc  = sat_hit ? bram_dout : bram_dout + DATA_W'(1);
  assign sat_flag = sat_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_q <= 1'b0;
    end else if ((state == ST_ACC_WB) && sat_hit) begin
      sat_q <= 1'b1;
    end else if (clr_accept) begin
      sat_q <= 1'b0;
    end
  end
`else
  assign acc_inc  = bram_dout + DATA_W'(1);
  assign sat_flag = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    acc_ready  = 1'b0;
    host_ready = 1'b0;
    case (state)
      ST_IDLE: begin
        if (clr_pend) begin
          state_nxt = ST_CLEAR;
        end else if (grant == GRANT_ACC) begin
          acc_ready = 1'b1;
          state_nxt = ST_ACC_RD;
        end else if (grant == GRANT_HOST) begin
          host_ready = 1'b1;
          state_nxt  = host_we ? ST_HOST_WR : ST_HOST_RD;
        end
      end
      ST_ACC_RD:   state_nxt = ST_ACC_WB;
      ST_ACC_WB:   state_nxt = ST_IDLE;
      ST_HOST_RD:  state_nxt = ST_HOST_RSP;
      ST_HOST_RSP: state_nxt = ST_IDLE;
      ST_HOST_WR:  state_nxt = ST_IDLE;
      ST_CLEAR:    state_nxt = clr_last ? ST_IDLE : ST_CLEAR;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  // A start arriving while a clear is already pending or running is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clr_pend <= 1'b0;
    end else if ((state == ST_IDLE) && clr_pend) begin
      clr_pend <= 1'b0;
    end else if (clr_accept) begin
      clr_pend <= 1'b1;
    end
  end

  // Port controls are registered from the next state so they line up with the
  // state that owns the cycle; address and data hold when the port is idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bram_en   <= 1'b0;
      bram_we   <= 1'b0;
      bram_addr <= '0;
      din_q     <= '0;
    end else begin
      if (state == ST_ACC_WB) begin
        din_q <= acc_inc;
      end
      case (state_nxt)
        ST_ACC_RD: begin
          bram_en   <= 1'b1;
          bram_we   <= 1'b0;
          bram_addr <= acc_addr;
        end
        ST_ACC_WB: begin
          bram_en <= 1'b1;
          bram_we <= 1'b1;
        end
        ST_HOST_RD: begin
          bram_en   <= 1'b1;
          bram_we   <= 1'b0;
          bram_addr <= host_addr;
        end
        ST_HOST_WR: begin
          bram_en   <= 1'b1;
          bram_we   <= 1'b1;
          bram_addr <= host_addr;
          din_q     <= host_wdata;
        end
        ST_CLEAR: begin
          bram_en   <= 1'b1;
          bram_we   <= 1'b1;
          bram_addr <= (state == ST_CLEAR) ? bram_addr + ADDR_W'(1) : '0;
          din_q     <= '0;
        end
        default: begin
          bram_en <= 1'b0;
          bram_we <= 1'b0;
        end
      endcase
    end
  end

  // Write-back data comes straight off the BRAM read port during ACC_WB.
  assign bram_din = (state == ST_ACC_WB) ? acc_inc : din_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      host_rvalid <= 1'b0;
      host_rdata  <= '0;
    end else begin
      host_rvalid <= (state == ST_HOST_RSP);
      if (state == ST_HOST_RSP) begin
        host_rdata <= bram_dout;
      end
    end
  end

endmodule
